cif_burst_sched: RTL and testbench
==================================

# cif_burst_sched

Burst-level scheduler that shares one CIF datapath between CH_NUM channel requesters. It takes per-channel requests with a burst length and selects a winner round-robin. It then holds that channel's grant for exactly the requested number of accepted beats, counted from a datapath beat strobe, and signals completion. It sits between the per-channel request logic and the shared CIF transfer datapath, replacing single-cycle grant pulses with burst-held ownership.

## Interface
- CH_NUM, 8, number of requesting channels (≥2)
- LEN_W, 8, width of per-channel burst length field; burst beats = req_len+1 (1..2^LEN_W)

- user_clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- arbenb  in  1  arbitration enable; sampled only in IDLE
- req  in  CH_NUM  per-channel request level
- req_len  in  CH_NUM*LEN_W  flattened lengths, ch i at [i*LEN_W +: LEN_W]
- beat_acc  in  1  datapath accepted one beat of granted channel this cycle
- abort  in  1  terminate current burst early
- gnt  out  CH_NUM  one-hot grant, held for whole burst
- gnt_ch  out  $clog2(CH_NUM)  index of granted channel (valid when busy)
- busy  out  1  a burst is in progress
- last_beat  out  1  combinational: busy & remaining beats == 1
- done  out  CH_NUM  one-cycle completion pulse, one-hot
- done_err  out  1  qualifies done: burst ended by abort

## Operation
- States: IDLE, XFER, GAP.
- IDLE: if arbenb & |req, the picker selects the first requesting channel starting at prio_ch and wrapping modulo CH_NUM. The block latches ch, loads remain = req_len[ch]+1 (LEN_W+1 bits, no overflow), and goes to XFER. Otherwise it stays in IDLE.
- XFER: gnt[ch]=1, busy=1. Each beat_acc decrements remain.
  - beat_acc with remain==1: go to GAP, done[ch]=1, done_err=0.
  - abort (with or without beat_acc): go to GAP, done[ch]=1, done_err=1. Abort has priority over normal completion.
- GAP: exactly one cycle with gnt=0 and busy=0, then IDLE. This lets a requester drop req in response to done before the next selection.
- prio_ch is updated to (ch+1) mod CH_NUM on entry to GAP, for both normal and abort completion. A channel at index CH_NUM-1 wraps to 0.
- While in XFER or GAP, changes to req, req_len and arbenb are ignored. Dropping req mid-burst does not end the burst.
- beat_acc outside XFER is ignored. remain never underflows.
- Reset (any state, asynchronous):
  - state=IDLE, prio_ch=0, remain=0, latched ch=0.
  - All outputs 0: gnt, gnt_ch, busy, last_beat, done, done_err.
  - Reset mid-burst drops the grant immediately and produces no done pulse.

## Timing
- Request sampled in IDLE at cycle T: gnt/busy registered high at T+1.
- A burst of N beats with beat_acc every cycle from T+1 occupies T+1..T+N. done pulses at T+N+1 (GAP), IDLE at T+N+2, and the earliest next gnt is at T+N+3.
- Throughput overhead is 2 idle cycles per burst.
- last_beat is combinational from remain, so the datapath can tag its final beat in the same cycle.
- done and done_err are registered, high for exactly one cycle, and coincide with the GAP cycle.
- gnt deasserts in the cycle after the final beat_acc or abort.

## Structure
- Shared package cif_sched_pkg holds:
  - state enum sched_state_e {IDLE, XFER, GAP}
  - localparam function for CH_NUM_W = $clog2(CH_NUM)
- Sub-module cif_rr_pick: purely combinational round-robin picker.
  - Inputs: req, prio_ch.
  - Outputs: one-hot pick and index.
  - Reused by other CIF schedulers.
- Top-level owns the FSM, remain counter, prio_ch register and output registers.

## Test plan
- Single burst: req=8'h04, req_len[2]=3, beat_acc held 1, arbenb=1. Expect gnt=8'h04 for 4 cycles, last_beat on the 4th, done=8'h04 one cycle later with done_err=0, then gnt=0 for 2 cycles.
- Round-robin fairness: req=8'hFF held, all lengths 0. Expect grant order ch0,1,2…7,0, with a new grant every 3 cycles.
- Wrap-around: after serving ch7 with req=8'h81, expect next grant ch0. Then, with only req=8'h80, expect ch7 again.
- Stalled beats and abort: len=9 (10 beats), beat_acc pulsed on 3 cycles, then abort. Expect done pulse with done_err=1 and prio_ch advanced past the aborted channel.
- Max length: req_len=8'hFF gives exactly 256 beats before done, with no early or late release.
- Async reset mid-XFER: gnt, busy and done drop to 0 immediately. After reset with req=8'h10, expect ch4 granted (prio restarts at 0, ch0–3 not requesting).

Source files
------------

// File: rtl/cif_sched_pkg.sv
// Shared types and sizing helpers for the CIF burst schedulers.
// The state enum and channel-index width are reused by every scheduler in the datapath.
package cif_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    // Index width for a channel count; never narrower than one bit.
    function automatic int ch_num_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/cif_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_prio_ch, wrapping.
// Zero latency; no flow control, o_vld is low when nothing requests.
module cif_rr_pick
    import cif_sched_pkg::*;
#(
    parameter  int CH_NUM   = 8,
    localparam int CH_NUM_W = ch_num_w(CH_NUM)
) (
    input  logic [CH_NUM-1:0]   i_req,
    input  logic [CH_NUM_W-1:0] i_prio_ch,
    output logic                o_vld,
    output logic [CH_NUM-1:0]   o_pick,
    output logic [CH_NUM_W-1:0] o_idx
);

    always_comb begin
        int c;
        c      = 0;
        o_vld  = 1'b0;
        o_pick = '0;
        o_idx  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            // Subtract rather than modulo so non-power-of-two channel counts stay cheap.
            c = int'(i_prio_ch) + k;
            if (c >= CH_NUM) c = c - CH_NUM;
            if (!o_vld && i_req[CH_NUM_W'(c)]) begin
                o_vld                  = 1'b1;
                o_idx                  = CH_NUM_W'(c);
                o_pick[CH_NUM_W'(c)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cif_burst_sched.sv
// Burst-held round-robin owner of the shared CIF datapath: grant at T+1, held for req_len+1 beats.
// Beats advance only on i_beat_acc; one GAP cycle with done follows each burst before re-arbitration.
module cif_burst_sched
    import cif_sched_pkg::*;
#(
    parameter  int CH_NUM   = 8,
    parameter  int LEN_W    = 8,
    localparam int CH_NUM_W = ch_num_w(CH_NUM)
) (
    input  logic                    user_clk,
    input  logic                    reset_n,
    input  logic                    i_arbenb,
    input  logic [CH_NUM-1:0]       i_req,
    input  logic [CH_NUM*LEN_W-1:0] i_req_len,
    input  logic                    i_beat_acc,
    input  logic                    i_abort,
    output logic [CH_NUM-1:0]       o_gnt,
    output logic [CH_NUM_W-1:0]     o_gnt_ch,
    output logic                    o_busy,
    output logic                    o_last_beat,
    output logic [CH_NUM-1:0]       o_done,
    output logic                    o_done_err
);

    sched_state_e          r_state;
    sched_state_e          w_next;
    logic [CH_NUM_W-1:0]   r_ch;
    logic [CH_NUM-1:0]     r_gnt;
    logic [CH_NUM_W-1:0]   r_prio;
    logic [LEN_W:0]        r_remain;
    logic [CH_NUM-1:0]     r_done;
    logic                  r_done_err;

    logic                  w_pick_vld;
    logic [CH_NUM-1:0]     w_pick_oh;
    logic [CH_NUM_W-1:0]   w_pick_idx;
    logic [LEN_W-1:0]      w_len_sel;
    logic                  w_start;
    logic                  w_finish;

    cif_rr_pick #(.CH_NUM(CH_NUM)) u_pick (
        .i_req     (i_req),
        .i_prio_ch (r_prio),
        .o_vld     (w_pick_vld),
        .o_pick    (w_pick_oh),
        .o_idx     (w_pick_idx)
    );

    assign w_len_sel = i_req_len[w_pick_idx*LEN_W +: LEN_W];
    assign w_start   = (r_state == IDLE) && i_arbenb && w_pick_vld;
    // Abort wins over a coincident final beat; both end the burst in the same cycle.
    assign w_finish  = (r_state == XFER) &&
                       (i_abort || (i_beat_acc && (r_remain == (LEN_W+1)'(1))));

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start)  w_next = XFER;
            XFER:    if (w_finish) w_next = GAP;
            GAP:                   w_next = IDLE;
            default:               w_next = IDLE;
        endcase
    end

    always_comb begin
        o_gnt       = '0;
        o_busy      = 1'b0;
        o_last_beat = 1'b0;
        if (r_state == XFER) begin
            o_gnt       = r_gnt;
            o_busy      = 1'b1;
            o_last_beat = (r_remain == (LEN_W+1)'(1));
        end
    end

    assign o_gnt_ch   = r_ch;
    assign o_done     = r_done;
    assign o_done_err = r_done_err;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch       <= '0;
            r_gnt      <= '0;
            r_prio     <= '0;
            r_remain   <= '0;
            r_done     <= '0;
            r_done_err <= 1'b0;
        end else begin
            r_done     <= '0;
            r_done_err <= 1'b0;
            if (w_start) begin
                r_ch     <= w_pick_idx;
                r_gnt    <= w_pick_oh;
                r_remain <= {1'b0, w_len_sel} + (LEN_W+1)'(1);
            end else if (r_state == XFER) begin
                if (i_beat_acc && (r_remain != '0))
                    r_remain <= r_remain - (LEN_W+1)'(1);
                if (w_finish) begin
                    r_done     <= r_gnt;
                    r_done_err <= i_abort;
                    r_prio     <= (r_ch == CH_NUM_W'(CH_NUM-1)) ? '0 : r_ch + CH_NUM_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cif_burst_sched.sv
// Bench for cif_burst_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against a burst-level ownership model.
module tb_cif_burst_sched;

    logic        user_clk = 1'b0;
    logic        reset_n;
    logic        arbenb;
    logic [7:0]  req;
    logic [63:0] req_len;
    logic        beat;
    logic        abort;
    logic [7:0]  o_gnt;
    logic [2:0]  o_gnt_ch;
    logic        o_busy;
    logic        o_last_beat;
    logic [7:0]  o_done;
    logic        o_done_err;

    int n_vec = 0;
    int n_err = 0;

    cif_burst_sched #(.CH_NUM(8), .LEN_W(8)) dut (
        .user_clk    (user_clk),
        .reset_n     (reset_n),
        .i_arbenb    (arbenb),
        .i_req       (req),
        .i_req_len   (req_len),
        .i_beat_acc  (beat),
        .i_abort     (abort),
        .o_gnt       (o_gnt),
        .o_gnt_ch    (o_gnt_ch),
        .o_busy      (o_busy),
        .o_last_beat (o_last_beat),
        .o_done      (o_done),
        .o_done_err  (o_done_err)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the datapath, how many beats are left, and the pulse owed.
    int         m_owner = -1;
    int         m_left  = 0;
    bit         m_gap   = 1'b0;
    int         m_prio  = 0;
    logic [7:0] m_done  = 8'h00;
    logic       m_err   = 1'b0;

    always @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_left = 0; m_gap = 1'b0; m_prio = 0; m_done = 8'h00; m_err = 1'b0;
        end else begin
            m_done = 8'h00;
            m_err  = 1'b0;
            if (m_owner >= 0) begin
                if (beat) m_left--;
                if (abort || m_left == 0) begin
                    m_done  = 8'h01 << m_owner;
                    m_err   = abort;
                    m_prio  = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_gap   = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (arbenb && req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (m_prio + k) % 8;
                    if (req[c]) begin
                        m_owner = c;
                        m_left  = int'(req_len[c*8 +: 8]) + 1;
                        break;
                    end
                end
            end
        end
    end

    always @(negedge user_clk) begin
        chk("gnt",       64'(o_gnt),       64'((m_owner >= 0) ? (8'h01 << m_owner) : 8'h00));
        chk("busy",      64'(o_busy),      64'(m_owner >= 0));
        chk("last_beat", 64'(o_last_beat), 64'(m_owner >= 0 && m_left == 1));
        chk("done",      64'(o_done),      64'(m_done));
        chk("done_err",  64'(o_done_err),  64'(m_err));
        if (m_owner >= 0) chk("gnt_ch", 64'(o_gnt_ch), 64'(m_owner));
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},    64'(o_gnt),       64'(0));
        chk({tag, "_busy"},   64'(o_busy),      64'(0));
        chk({tag, "_last"},   64'(o_last_beat), 64'(0));
        chk({tag, "_done"},   64'(o_done),      64'(0));
        chk({tag, "_err"},    64'(o_done_err),  64'(0));
        chk({tag, "_gntch"},  64'(o_gnt_ch),    64'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("rst");
        tick();
        reset_n = 1'b1;
    endtask

    // Waits out any current burst, then for the next grant; bounded.
    task automatic wait_grant(output int ch, output logic [7:0] g);
        int n;
        n = 0;
        while (o_busy && n < 600) begin tick(); n++; end
        while (!o_busy && n < 600) begin tick(); n++; end
        chk("grant_timeout", 64'(n < 600), 64'(1));
        ch = int'(o_gnt_ch);
        g  = o_gnt;
    endtask

    initial begin
        int         ch;
        logic [7:0] g;
        int         cnt;
        int         lastpos;
        int         n;
        int         gcount;
        int         last_t;

        reset_n = 1'b0; arbenb = 1'b0; req = 8'h00; req_len = 64'h0; beat = 1'b0; abort = 1'b0;
        #1;
        chk_idle_outputs("por");
        tick(); tick();
        reset_n = 1'b1;

        // Single 4-beat burst on ch2.
        arbenb = 1'b1; req = 8'h04; req_len[2*8 +: 8] = 8'd3; beat = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("single_gnt",  64'(o_gnt),       64'(8'h04));
            chk("single_last", 64'(o_last_beat), 64'(k == 3));
            tick();
        end
        chk("single_done",     64'(o_done),     64'(8'h04));
        chk("single_done_err", 64'(o_done_err), 64'(0));
        chk("single_gap_gnt",  64'(o_gnt),      64'(0));
        tick();
        chk("single_idle_gnt",  64'(o_gnt),  64'(0));
        chk("single_idle_done", 64'(o_done), 64'(0));
        req = 8'h00;
        tick();
        chk("single_quiet_gnt", 64'(o_gnt), 64'(0));

        // Round-robin fairness, all requesting single beats.
        do_reset();
        req = 8'hFF; req_len = 64'h0; beat = 1'b1;
        tick();
        gcount = 0; last_t = 0;
        for (int t = 0; t < 27; t++) begin
            if (o_busy) begin
                chk("rr_order", 64'(o_gnt_ch), 64'(gcount % 8));
                if (gcount > 0) chk("rr_period", 64'(t - last_t), 64'(3));
                last_t = t;
                gcount++;
            end
            tick();
        end
        chk("rr_count", 64'(gcount), 64'(9));

        // Wrap-around: ch7 alone, then ch0 after ch7, then ch7 again.
        do_reset();
        req = 8'h80;
        wait_grant(ch, g);
        chk("wrap_first_ch7", 64'(ch), 64'(7));
        req = 8'h81;
        wait_grant(ch, g);
        chk("wrap_ch0", 64'(ch), 64'(0));
        chk("wrap_ch0_gnt", 64'(g), 64'(8'h01));
        req = 8'h80;
        wait_grant(ch, g);
        chk("wrap_ch7", 64'(ch), 64'(7));

        // Stalled beats then abort on ch5 (10-beat burst).
        req = 8'h20; req_len[5*8 +: 8] = 8'd9;
        wait_grant(ch, g);
        chk("abort_grant", 64'(ch), 64'(5));
        beat = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat = 1'b1; tick();
            beat = 1'b0; tick();
            chk("abort_still_busy", 64'(o_busy), 64'(1));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done",     64'(o_done),     64'(8'h20));
        chk("abort_done_err", 64'(o_done_err), 64'(1));
        chk("abort_gnt_off",  64'(o_gnt),      64'(0));
        req = 8'h60; req_len[6*8 +: 8] = 8'd0; beat = 1'b1;
        wait_grant(ch, g);
        chk("abort_prio_adv", 64'(ch), 64'(6));

        // Maximum length: 256 beats on ch3.
        req = 8'h08; req_len[3*8 +: 8] = 8'hFF;
        wait_grant(ch, g);
        chk("max_grant", 64'(ch), 64'(3));
        req = 8'h00;
        cnt = 0; lastpos = -1; n = 0;
        while (!o_done && n < 400) begin
            if (o_busy) begin
                cnt++;
                if (o_last_beat) lastpos = cnt;
            end
            tick();
            n++;
        end
        chk("max_beats",    64'(cnt),     64'(256));
        chk("max_last_pos", 64'(lastpos), 64'(256));
        chk("max_done",     64'(o_done),  64'(8'h08));

        // Asynchronous reset in the middle of a burst.
        req = 8'h02; req_len[1*8 +: 8] = 8'd20;
        wait_grant(ch, g);
        tick(); tick();
        chk("arst_pre_busy", 64'(o_busy), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk_idle_outputs("arst");
        req = 8'h10; req_len[4*8 +: 8] = 8'd0;
        #3 reset_n = 1'b1;
        wait_grant(ch, g);
        chk("arst_prio_restart", 64'(ch), 64'(4));
        chk("arst_gnt",          64'(g),  64'(8'h10));

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            arbenb = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int c = 0; c < 8; c++)
                    req_len[c*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                                     : 8'($urandom_range(0, 5));
            end
            beat  = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 40) == 0);
            if (i == 2500) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            tick();
        end
        arbenb = 1'b0; req = 8'h00; beat = 1'b0; abort = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
